regfile_sequencer: RTL and testbench
====================================

// Module: regfile_sequencer
// PURPOSE
//  Initiator side of the Registers read/write interface. Accepts one operation
//  command: src A, src B, dst, write-enable. Drives the register file's read
//  strobe/addresses, captures datA/datB and hands operands to the ALU. Takes the
//  ALU result back and issues the write strobe to the register file.
//  One command in flight.
// PARAMETERS
//  DATA_W      32   operand/result width (matches register file data width)
//  ADDR_W      4    register address width (matches dirA/dirB/dir_WR)
//  NUM_REGS    16   implemented registers; addresses >= NUM_REGS are illegal
//  RES_TIMEOUT 255  max cycles in WAIT_RES before abort (8-bit counter)
// PORTS
//  clk          in   1       system clock, all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       sequencer can accept command (=1 only in IDLE)
//  cmd_src_a    in   ADDR_W  operand A register address
//  cmd_src_b    in   ADDR_W  operand B register address
//  cmd_dst      in   ADDR_W  destination register address
//  cmd_wr_en    in   1       1: write result back; 0: operands only
//  rf_read      out  1       register file read strobe (reg_read)
//  rf_dir_a     out  ADDR_W  register file dirA
//  rf_dir_b     out  ADDR_W  register file dirB
//  rf_datA      in   DATA_W  register file datA (registered in RF on posedge)
//  rf_datB      in   DATA_W  register file datB
//  rf_write     out  1       register file write strobe (reg_write; RF writes on negedge)
//  rf_dir_wr    out  ADDR_W  register file dir_WR
//  rf_data      out  DATA_W  register file data_in
//  op_valid     out  1       operands valid to ALU
//  op_ready     in   1       ALU accepts operands
//  op_a, op_b   out  DATA_W  captured operands
//  res_valid    in   1       ALU result present
//  res_ready    out  1       sequencer accepts result
//  res_data     in   DATA_W  ALU result
//  err          out  1       one-cycle pulse: illegal address or result timeout
// BEHAVIOUR
//  - All outputs registered or Moore-decoded from state.
//  - Reset: state=IDLE, cmd_ready=1, rf_read=rf_write=op_valid=res_ready=err=0.
//    Addresses, rf_data, op_a and op_b reset to 0.
//  - States: IDLE -> READ -> CAPT -> ISSUE -> [WAIT_RES -> WRITE] -> IDLE.
//  - IDLE: cmd_valid&cmd_ready at edge T latches src_a/src_b/dst/wr_en.
//    Moves to READ.
//  - READ (T+1 cycle): rf_read=1, rf_dir_a/b = latched srcs. Next CAPT.
//  - CAPT (T+2 cycle): op_a<=rf_datA, op_b<=rf_datB at its closing edge. Next ISSUE.
//  - ISSUE: op_valid=1 from cycle T+3, held stable until op_valid&op_ready.
//    Then WAIT_RES if wr_en=1, else IDLE.
//  - WAIT_RES: res_ready=1. res_valid&res_ready latches res_data into rf_data.
//    Next WRITE. Timeout counter clears on entry. Reaching RES_TIMEOUT cycles
//    without a result: err pulse, return to IDLE, no write.
//  - WRITE: exactly one cycle. rf_write=1, rf_dir_wr=dst, rf_data=result.
//    RF commits at that cycle's negedge. Next IDLE.
//  - Back-to-back: new command accepted in IDLE the cycle after WRITE.
//    A read in READ therefore sees the prior write (committed at earlier negedge).
//  - Illegal src (>=NUM_REGS) at accept: operand forced to 0, err pulse in READ.
//    Illegal dst with wr_en=1: err pulse in WRITE, rf_write held 0.
//  - rst mid-operation: state->IDLE at the next edge, in-flight command dropped.
//    If rst is sampled at the end of WRITE, the negedge write of that cycle has
//    already occurred. No other write issued.
//  - res_valid outside WAIT_RES is ignored (res_ready=0).
// CONFIGURATION
//  REGSEQ_ZERO_REG_EN defined:
//  - src address 0 yields operand 0 regardless of rf_datA/rf_datB.
//  - wr_en with dst 0 completes WAIT_RES normally but rf_write stays 0 (no err).
//  Undefined: register 0 is an ordinary register.
// TESTING
//  1. Reset: hold rst 2 cycles -> cmd_ready=1, all strobes 0, err=0.
//  2. cmd src_a=1,src_b=2,dst=3,wr_en=1; RF r1=5,r2=7; ALU returns 12.
//     -> rf_read at T+1, op_valid at T+3 with a=5,b=7, rf_write one cycle, dir_wr=3, data=12.
//  3. Back-to-back: write r3=12, then cmd src_a=3 -> op_a=12. op_ready held low 4 cycles
//     -> op_valid and op_a stable throughout.
//  4. wr_en=0 -> IDLE after op handshake, rf_write never 1. cmd_src_b=15 with NUM_REGS=8
//     -> op_b=0, err pulse.
//  5. No res_valid for 255 cycles -> err pulse, IDLE, no write. rst asserted in WAIT_RES
//     -> IDLE next cycle, no write.
//  6. REGSEQ_ZERO_REG_EN: RF r0=9, src_a=0 -> op_a=0. dst=0 -> rf_write stays 0.
//     Without macro -> op_a=9, write issued.

Source files
------------

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: initiator side of the register file read/write interface.
// It takes one command, reads both source registers, hands the operands to the
// ALU, and optionally writes the ALU result back to the destination register.
// Optional build macro: REGSEQ_ZERO_REG_EN makes register 0 read as zero and
// drops writes to it.
module regfile_sequencer #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned RES_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic              cmd_wr_en,
    output logic              rf_read,
    output logic [ADDR_W-1:0] rf_dir_a,
    output logic [ADDR_W-1:0] rf_dir_b,
    input  logic [DATA_W-1:0] rf_datA,
    input  logic [DATA_W-1:0] rf_datB,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_dir_wr,
    output logic [DATA_W-1:0] rf_data,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    output logic              err
);

    localparam int unsigned CNT_W = 8;

`ifdef REGSEQ_ZERO_REG_EN
    localparam bit ZERO_REG_EN = 1'b1;
`else
    localparam bit ZERO_REG_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_ISSUE,
        S_WAIT_RES,
        S_WRITE
    } state_t;

    function automatic logic addr_illegal(input logic [ADDR_W-1:0] a);
        return 32'(a) >= NUM_REGS;
    endfunction

    function automatic logic addr_zero_reg(input logic [ADDR_W-1:0] a);
        return ZERO_REG_EN && (a == '0);
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic                wr_en_q, wr_en_d;
    logic                zero_a_q, zero_a_d;
    logic                zero_b_q, zero_b_d;
    logic                dst_bad_q, dst_bad_d;
    logic                dst_drop_q, dst_drop_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                rf_read_q, rf_read_d;
    logic [ADDR_W-1:0]   rf_dir_a_q, rf_dir_a_d;
    logic [ADDR_W-1:0]   rf_dir_b_q, rf_dir_b_d;
    logic                rf_write_q, rf_write_d;
    logic [ADDR_W-1:0]   rf_dir_wr_q, rf_dir_wr_d;
    logic [DATA_W-1:0]   rf_data_q, rf_data_d;
    logic                op_valid_q, op_valid_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic                res_ready_q, res_ready_d;
    logic                err_q, err_d;

    // Next-state and next-output decode; strobes follow the upcoming state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dst_d       = dst_q;
        wr_en_d     = wr_en_q;
        zero_a_d    = zero_a_q;
        zero_b_d    = zero_b_q;
        dst_bad_d   = dst_bad_q;
        dst_drop_d  = dst_drop_q;
        rf_dir_a_d  = rf_dir_a_q;
        rf_dir_b_d  = rf_dir_b_q;
        rf_dir_wr_d = rf_dir_wr_q;
        rf_data_d   = rf_data_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rf_write_d  = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    rf_dir_a_d = cmd_src_a;
                    rf_dir_b_d = cmd_src_b;
                    dst_d      = cmd_dst;
                    wr_en_d    = cmd_wr_en;
                    zero_a_d   = addr_illegal(cmd_src_a) || addr_zero_reg(cmd_src_a);
                    zero_b_d   = addr_illegal(cmd_src_b) || addr_zero_reg(cmd_src_b);
                    dst_bad_d  = addr_illegal(cmd_dst);
                    dst_drop_d = addr_illegal(cmd_dst) || addr_zero_reg(cmd_dst);
                    err_d      = addr_illegal(cmd_src_a) || addr_illegal(cmd_src_b);
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                op_a_d  = zero_a_q ? '0 : rf_datA;
                op_b_d  = zero_b_q ? '0 : rf_datB;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (op_valid_q && op_ready) begin
                    cnt_d   = '0;
                    state_d = wr_en_q ? S_WAIT_RES : S_IDLE;
                end
            end
            S_WAIT_RES: begin
                if (res_valid && res_ready_q) begin
                    rf_data_d   = res_data;
                    rf_dir_wr_d = dst_q;
                    rf_write_d  = !dst_drop_q;
                    err_d       = dst_bad_q;
                    state_d     = S_WRITE;
                end else if (cnt_q == CNT_W'(RES_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        rf_read_d   = (state_d == S_READ);
        op_valid_d  = (state_d == S_ISSUE);
        res_ready_d = (state_d == S_WAIT_RES);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dst_q       <= '0;
            wr_en_q     <= 1'b0;
            zero_a_q    <= 1'b0;
            zero_b_q    <= 1'b0;
            dst_bad_q   <= 1'b0;
            dst_drop_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            rf_read_q   <= 1'b0;
            rf_dir_a_q  <= '0;
            rf_dir_b_q  <= '0;
            rf_write_q  <= 1'b0;
            rf_dir_wr_q <= '0;
            rf_data_q   <= '0;
            op_valid_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_ready_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dst_q       <= dst_d;
            wr_en_q     <= wr_en_d;
            zero_a_q    <= zero_a_d;
            zero_b_q    <= zero_b_d;
            dst_bad_q   <= dst_bad_d;
            dst_drop_q  <= dst_drop_d;
            cmd_ready_q <= cmd_ready_d;
            rf_read_q   <= rf_read_d;
            rf_dir_a_q  <= rf_dir_a_d;
            rf_dir_b_q  <= rf_dir_b_d;
            rf_write_q  <= rf_write_d;
            rf_dir_wr_q <= rf_dir_wr_d;
            rf_data_q   <= rf_data_d;
            op_valid_q  <= op_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            res_ready_q <= res_ready_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rf_read   = rf_read_q;
    assign rf_dir_a  = rf_dir_a_q;
    assign rf_dir_b  = rf_dir_b_q;
    assign rf_write  = rf_write_q;
    assign rf_dir_wr = rf_dir_wr_q;
    assign rf_data   = rf_data_q;
    assign op_valid  = op_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign res_ready = res_ready_q;
    assign err       = err_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed testbench for regfile_sequencer with a small register file model
// (posedge-registered reads, negedge writes). Build with REGSEQ_ZERO_REG_EN to
// exercise the zero-register variant.
module tb_regfile_sequencer;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 8;

`ifdef REGSEQ_ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_src_a = '0;
    logic [ADDR_W-1:0] cmd_src_b = '0;
    logic [ADDR_W-1:0] cmd_dst = '0;
    logic              cmd_wr_en = 1'b0;
    logic              rf_read;
    logic [ADDR_W-1:0] rf_dir_a;
    logic [ADDR_W-1:0] rf_dir_b;
    logic [DATA_W-1:0] rf_datA = '0;
    logic [DATA_W-1:0] rf_datB = '0;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_dir_wr;
    logic [DATA_W-1:0] rf_data;
    logic              op_valid;
    logic              op_ready = 1'b0;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              res_valid = 1'b0;
    logic              res_ready;
    logic [DATA_W-1:0] res_data = '0;
    logic              err;

    logic [DATA_W-1:0] regs [16];
    int                wr_count = 0;
    int                n_checks = 0;
    int                n_errors = 0;

    regfile_sequencer #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .RES_TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst), .cmd_wr_en(cmd_wr_en),
        .rf_read(rf_read), .rf_dir_a(rf_dir_a), .rf_dir_b(rf_dir_b),
        .rf_datA(rf_datA), .rf_datB(rf_datB),
        .rf_write(rf_write), .rf_dir_wr(rf_dir_wr), .rf_data(rf_data),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .err(err)
    );

    always #5 clk = ~clk;

    // Register file model: read data registered on posedge.
    always @(posedge clk) begin
        if (rf_read) begin
            rf_datA <= regs[rf_dir_a];
            rf_datB <= regs[rf_dir_b];
        end
    end

    // Register file model: writes commit on negedge.
    always @(negedge clk) begin
        if (rf_write) begin
            regs[rf_dir_wr] = rf_data;
            wr_count++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command for one cycle; returns positioned in READ.
    task automatic send_cmd(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] d, input logic we);
        cmd_src_a = a; cmd_src_b = b; cmd_dst = d; cmd_wr_en = we;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("read_strobe", 32'(rf_read), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wc;
        for (int i = 0; i < 16; i++) regs[i] = 32'h100 + 32'(i);
        regs[0]  = 32'd9;
        regs[1]  = 32'd5;
        regs[2]  = 32'd7;
        regs[15] = 32'hDEAD;

        // 1. Reset
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_strobes", {28'd0, rf_read, rf_write, op_valid, res_ready}, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_op_a", op_a, 32'd0);
        check("rst_dir_a", 32'(rf_dir_a), 32'd0);
        step();

        // 2. Basic write-back command
        op_ready = 1'b1;
        send_cmd(4'd1, 4'd2, 4'd3, 1'b1);
        check("t2_dirs", {24'd0, rf_dir_a, rf_dir_b}, 32'h12);
        check("t2_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        check("t2_opv_read", 32'(op_valid), 32'd0);
        step();
        check("t2_opv_capt", 32'(op_valid), 32'd0);
        check("t2_read_off", 32'(rf_read), 32'd0);
        step();
        check("t2_opv_issue", 32'(op_valid), 32'd1);
        check("t2_op_a", op_a, 32'd5);
        check("t2_op_b", op_b, 32'd7);
        step();
        check("t2_res_ready", 32'(res_ready), 32'd1);
        check("t2_opv_drop", 32'(op_valid), 32'd0);
        res_valid = 1'b1; res_data = 32'd12;
        step();
        res_valid = 1'b0;
        check("t2_write", 32'(rf_write), 32'd1);
        check("t2_dir_wr", 32'(rf_dir_wr), 32'd3);
        check("t2_data", rf_data, 32'd12);
        check("t2_err", 32'(err), 32'd0);
        step();
        check("t2_write_one", 32'(rf_write), 32'd0);
        check("t2_idle", 32'(cmd_ready), 32'd1);
        check("t2_wr_count", 32'(wr_count), 32'd1);

        // 3. Back-to-back read of the just-written r3 with stalled ALU
        op_ready = 1'b0;
        send_cmd(4'd3, 4'd1, 4'd4, 1'b0);
        step(); step();
        for (int i = 0; i < 4; i++) begin
            check("t3_opv_hold", 32'(op_valid), 32'd1);
            check("t3_op_a_hold", op_a, 32'd12);
            step();
        end
        check("t3_opv_still", 32'(op_valid), 32'd1);
        op_ready = 1'b1;
        step();
        check("t3_idle", 32'(cmd_ready), 32'd1);
        check("t3_opv_off", 32'(op_valid), 32'd0);
        step();

        // 4. Operands only, illegal src_b; stray res_valid ignored
        res_valid = 1'b1; res_data = 32'h55;
        send_cmd(4'd2, 4'd15, 4'd5, 1'b0);
        check("t4_err_read", 32'(err), 32'd1);
        check("t4_res_ready_off", 32'(res_ready), 32'd0);
        step();
        check("t4_err_pulse", 32'(err), 32'd0);
        step();
        check("t4_op_a", op_a, 32'd7);
        check("t4_op_b_forced", op_b, 32'd0);
        step();
        check("t4_idle", 32'(cmd_ready), 32'd1);
        step();
        res_valid = 1'b0;
        check("t4_no_write", 32'(wr_count), 32'd1);

        // 4b. Illegal destination with write enable
        send_cmd(4'd1, 4'd2, 4'd9, 1'b1);
        step(); step(); step();
        res_valid = 1'b1; res_data = 32'h77;
        step();
        res_valid = 1'b0;
        check("t4b_err_write", 32'(err), 32'd1);
        check("t4b_no_strobe", 32'(rf_write), 32'd0);
        step();
        check("t4b_wr_count", 32'(wr_count), 32'd1);

        // 5. Result timeout
        send_cmd(4'd1, 4'd2, 4'd3, 1'b1);
        step(); step(); step();
        check("t5_wait", 32'(res_ready), 32'd1);
        n = 0;
        while (res_ready && n < 400) begin
            check("t5_no_early_err", 32'(err), 32'd0);
            step();
            n++;
        end
        check("t5_wait_cycles", 32'(n), 32'd255);
        check("t5_err", 32'(err), 32'd1);
        check("t5_idle", 32'(cmd_ready), 32'd1);
        step();
        check("t5_err_pulse", 32'(err), 32'd0);
        check("t5_no_write", 32'(wr_count), 32'd1);

        // 5b. Reset while waiting for a result
        send_cmd(4'd1, 4'd2, 4'd6, 1'b1);
        step(); step(); step(); step();
        check("t5b_wait", 32'(res_ready), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5b_idle", 32'(cmd_ready), 32'd1);
        check("t5b_res_ready_off", 32'(res_ready), 32'd0);
        res_valid = 1'b1; res_data = 32'h99;
        step(); step();
        res_valid = 1'b0;
        check("t5b_no_write", 32'(wr_count), 32'd1);
        check("t5b_r6_kept", regs[6], 32'h106);

        // 6. Register 0 behaviour
        send_cmd(4'd0, 4'd1, 4'd0, 1'b1);
        step(); step();
        check("t6_op_a", op_a, ZERO_EN ? 32'd0 : 32'd9);
        check("t6_op_b", op_b, 32'd5);
        step();
        res_valid = 1'b1; res_data = 32'd33;
        step();
        res_valid = 1'b0;
        check("t6_write", 32'(rf_write), ZERO_EN ? 32'd0 : 32'd1);
        check("t6_err", 32'(err), 32'd0);
        step();
        wc = ZERO_EN ? 1 : 2;
        check("t6_wr_count", 32'(wr_count), 32'(wc));
        check("t6_r0", regs[0], ZERO_EN ? 32'd9 : 32'd33);
        check("t6_idle", 32'(cmd_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
